rpu_ibd_pkt_tracker: RTL and testbench

Inbound packet tracker for the RPU. It sits directly downstream of the inbound-flit decoder and consumes its per-flit outputs: the head-flit fields, the flit type, and the accepted-flit handshake. It latches the packet header, counts accepted flits up to the tail, and checks the count against the header's flit count. On completion it emits a one-cycle completion pulse with the registered packet descriptor and error flags to the RPU controller and register file.

---
 rtl/nou_pkg.sv | 36 +++
 rtl/rpu_ibd_flit_cnt.sv | 43 ++++
 rtl/rpu_ibd_pkt_tracker.sv | 169 ++++++++++++++++
 tb/tb_rpu_ibd_pkt_tracker.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nou_pkg.sv
// Shared NoU definitions: field widths, flit type codes, tracker state and packet descriptor.
package nou_pkg;

  localparam int NOU_TYPE_WIDTH          = 2;
  localparam int NOU_TID_WIDTH           = 8;
  localparam int NOU_TILE_ID_WIDTH       = 4;
  localparam int NOU_PKT_ID_WIDTH        = 16;
  localparam int NOU_PKT_HEADER_SZ_WIDTH = 4;
  localparam int NOU_PKT_DATA_SZ_WIDTH   = 12;
  localparam int NOU_FLIT_SZ_WIDTH       = 8;

  // Codes mirror nou_define.h; the unused code 3 is handled as a body flit.
  localparam logic [NOU_TYPE_WIDTH-1:0] HEAD_FLIT_TYPE = 2'd0;
  localparam logic [NOU_TYPE_WIDTH-1:0] BODY_FLIT_TYPE = 2'd1;
  localparam logic [NOU_TYPE_WIDTH-1:0] TAIL_FLIT_TYPE = 2'd2;

  typedef enum logic [0:0] {
    TRK_IDLE = 1'b0,
    TRK_RECV = 1'b1
  } trk_state_e;

  typedef struct packed {
    logic [NOU_TID_WIDTH-1:0]           tid;
    logic [NOU_TILE_ID_WIDTH-1:0]       local_tile;
    logic [NOU_TILE_ID_WIDTH-1:0]       dst_tile;
    logic [NOU_PKT_ID_WIDTH-1:0]        pkt_id;
    logic [NOU_PKT_HEADER_SZ_WIDTH-1:0] hdr_size;
    logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   data_size;
    logic [NOU_FLIT_SZ_WIDTH-1:0]       flit_num;
  } pkt_desc_t;

  function automatic logic is_single_flit(input logic [NOU_FLIT_SZ_WIDTH-1:0] flit_num);
    return flit_num <= NOU_FLIT_SZ_WIDTH'(1);
  endfunction

endpackage

// File: rtl/rpu_ibd_flit_cnt.sv
// Saturating received-flit counter with load-to-one, plus compares against the expected flit count.
module rpu_ibd_flit_cnt
  import nou_pkg::*;
#(
  parameter int CNT_W = NOU_FLIT_SZ_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         load_one,
  input  logic                         inc,
  input  logic [NOU_FLIT_SZ_WIDTH-1:0] cmp_num,
  output logic [CNT_W-1:0]             cnt,
  output logic                         inc_eq,
  output logic                         fin_eq
);

  localparam int CMP_W = (CNT_W + 1 > NOU_FLIT_SZ_WIDTH) ? CNT_W + 1 : NOU_FLIT_SZ_WIDTH;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = sat_inc(cnt);
  assign inc_eq  = (CMP_W'(cnt_inc) == CMP_W'(cmp_num));
  // The tail compare uses the unsaturated sum so a pinned counter still reads as too long.
  assign fin_eq  = ((CMP_W'(cnt) + CMP_W'(1)) == CMP_W'(cmp_num));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load_one) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/rpu_ibd_pkt_tracker.sv
// Inbound packet tracker: latches the head, counts accepted flits and reports completion/errors.
module rpu_ibd_pkt_tracker
  import nou_pkg::*;
#(
  parameter int CNT_W = NOU_FLIT_SZ_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ib_vld,
  input  logic                               id_ready,
  input  logic [NOU_TYPE_WIDTH-1:0]          ib_type,
  input  logic                               lreg_vld,
  input  logic [NOU_TID_WIDTH-1:0]           trans_id,
  input  logic [NOU_TILE_ID_WIDTH-1:0]       local_tile_id,
  input  logic [NOU_TILE_ID_WIDTH-1:0]       dst_tile_id,
  input  logic [NOU_PKT_ID_WIDTH-1:0]        pkt_id,
  input  logic [NOU_PKT_HEADER_SZ_WIDTH-1:0] pkt_header_size,
  input  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   pkt_data_size,
  input  logic [NOU_FLIT_SZ_WIDTH-1:0]       pkt_flit_num,
  input  logic [NOU_TILE_ID_WIDTH-1:0]       cfg_tile_id,
  output logic                               busy,
  output logic [CNT_W-1:0]                   rx_flit_cnt,
  output logic                               pkt_done,
  output logic [NOU_TID_WIDTH-1:0]           pkt_desc_trans_id,
  output logic [NOU_TILE_ID_WIDTH-1:0]       pkt_desc_local_tile_id,
  output logic [NOU_TILE_ID_WIDTH-1:0]       pkt_desc_dst_tile_id,
  output logic [NOU_PKT_ID_WIDTH-1:0]        pkt_desc_pkt_id,
  output logic [NOU_PKT_HEADER_SZ_WIDTH-1:0] pkt_desc_header_size,
  output logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   pkt_desc_data_size,
  output logic [NOU_FLIT_SZ_WIDTH-1:0]       pkt_desc_flit_num,
  output logic                               err_len,
  output logic                               err_dst,
  output logic                               err_orphan,
  output logic                               err_abort
);

  trk_state_e state_q;
  pkt_desc_t  desc_q;
  pkt_desc_t  shadow_q;
  pkt_desc_t  head_d;
  pkt_desc_t  act_desc;
  logic       shadow_vld_q;
  logic       len_over_q;
  logic       dst_err_q;
  logic       pend_single_q;
  logic       pend_len_err_q;

  logic acc, head_evt, flit_evt, tail_evt, body_evt, in_recv;
  logic new_dst_err, new_single, new_len_err;
  logic comp_tail, comp_abort, comp_old, old_len_err;
  logic inc_eq, fin_eq;

  assign acc      = ib_vld & id_ready;
  assign head_evt = lreg_vld;
  assign flit_evt = acc & ~lreg_vld & (ib_type != HEAD_FLIT_TYPE);
  assign tail_evt = flit_evt & (ib_type == TAIL_FLIT_TYPE);
  assign body_evt = flit_evt & (ib_type != TAIL_FLIT_TYPE);
  assign in_recv  = (state_q == TRK_RECV);

  assign head_d = '{tid:        trans_id,
                    local_tile: local_tile_id,
                    dst_tile:   dst_tile_id,
                    pkt_id:     pkt_id,
                    hdr_size:   pkt_header_size,
                    data_size:  pkt_data_size,
                    flit_num:   pkt_flit_num};

  // The packet being tracked lives in the shadow for one cycle after an abort.
  assign act_desc    = shadow_vld_q ? shadow_q : desc_q;
  assign new_dst_err = (dst_tile_id != cfg_tile_id);
  assign new_single  = is_single_flit(pkt_flit_num);
  assign new_len_err = (pkt_flit_num == '0);

  assign comp_tail   = in_recv & tail_evt;
  assign comp_abort  = in_recv & head_evt;
  assign comp_old    = comp_tail | comp_abort | pend_single_q;
  assign old_len_err = comp_abort ? 1'b1 :
                       comp_tail  ? (~fin_eq | len_over_q) : pend_len_err_q;

  rpu_ibd_flit_cnt #(
    .CNT_W(CNT_W)
  ) u_flit_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load_one (head_evt),
    .inc      (in_recv & flit_evt),
    .cmp_num  (act_desc.flit_num),
    .cnt      (rx_flit_cnt),
    .inc_eq   (inc_eq),
    .fin_eq   (fin_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= TRK_IDLE;
      desc_q         <= '0;
      shadow_q       <= '0;
      shadow_vld_q   <= 1'b0;
      len_over_q     <= 1'b0;
      dst_err_q      <= 1'b0;
      pend_single_q  <= 1'b0;
      pend_len_err_q <= 1'b0;
      pkt_done       <= 1'b0;
      err_len        <= 1'b0;
      err_dst        <= 1'b0;
      err_orphan     <= 1'b0;
      err_abort      <= 1'b0;
    end else begin
      pkt_done       <= 1'b0;
      err_len        <= 1'b0;
      err_dst        <= 1'b0;
      err_orphan     <= 1'b0;
      err_abort      <= 1'b0;
      pend_single_q  <= 1'b0;
      pend_len_err_q <= 1'b0;
      if (shadow_vld_q) begin
        desc_q       <= shadow_q;
        shadow_vld_q <= 1'b0;
      end
      if (comp_old) begin
        pkt_done <= 1'b1;
        err_len  <= old_len_err;
        err_dst  <= dst_err_q;
      end
      if (head_evt) begin
        dst_err_q  <= new_dst_err;
        len_over_q <= 1'b0;
        err_abort  <= in_recv;
        // When an older packet completes on this edge, the descriptor must show it, so park the new head.
        if (comp_old) begin
          shadow_q     <= head_d;
          shadow_vld_q <= 1'b1;
        end else begin
          desc_q <= head_d;
        end
        if (new_single) begin
          state_q <= TRK_IDLE;
          if (comp_old) begin
            pend_single_q  <= 1'b1;
            pend_len_err_q <= new_len_err;
          end else begin
            pkt_done <= 1'b1;
            err_len  <= new_len_err;
            err_dst  <= new_dst_err;
          end
        end else begin
          state_q <= TRK_RECV;
        end
      end else if (in_recv && body_evt) begin
        if (inc_eq) len_over_q <= 1'b1;
      end else if (in_recv && tail_evt) begin
        state_q <= TRK_IDLE;
      end else if (!in_recv && flit_evt) begin
        err_orphan <= 1'b1;
      end
    end
  end

  assign busy                   = (state_q == TRK_RECV);
  assign pkt_desc_trans_id      = desc_q.tid;
  assign pkt_desc_local_tile_id = desc_q.local_tile;
  assign pkt_desc_dst_tile_id   = desc_q.dst_tile;
  assign pkt_desc_pkt_id        = desc_q.pkt_id;
  assign pkt_desc_header_size   = desc_q.hdr_size;
  assign pkt_desc_data_size     = desc_q.data_size;
  assign pkt_desc_flit_num      = desc_q.flit_num;

endmodule

// File: tb/tb_rpu_ibd_pkt_tracker.sv
// Bench for rpu_ibd_pkt_tracker: vector table, directed corner sequences and a queue-based reference model.
module tb_rpu_ibd_pkt_tracker;
  import nou_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                               ib_vld, id_ready, lreg_vld;
  logic [NOU_TYPE_WIDTH-1:0]          ib_type;
  logic [NOU_TID_WIDTH-1:0]           trans_id;
  logic [NOU_TILE_ID_WIDTH-1:0]       local_tile_id, dst_tile_id, cfg_tile_id;
  logic [NOU_PKT_ID_WIDTH-1:0]        pkt_id;
  logic [NOU_PKT_HEADER_SZ_WIDTH-1:0] pkt_header_size;
  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   pkt_data_size;
  logic [NOU_FLIT_SZ_WIDTH-1:0]       pkt_flit_num;

  logic                               busy_w, done_w, len_w, dst_w, orph_w, abort_w;
  logic [7:0]                         cnt_w;
  logic [NOU_TID_WIDTH-1:0]           d_tid_w;
  logic [NOU_TILE_ID_WIDTH-1:0]       d_lt_w, d_dt_w;
  logic [NOU_PKT_ID_WIDTH-1:0]        d_pid_w;
  logic [NOU_PKT_HEADER_SZ_WIDTH-1:0] d_hs_w;
  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   d_ds_w;
  logic [NOU_FLIT_SZ_WIDTH-1:0]       d_fn_w;

  logic                               busy_n, done_n, len_n, dst_n, orph_n, abort_n;
  logic [1:0]                         cnt_n;
  logic [NOU_TID_WIDTH-1:0]           d_tid_n;
  logic [NOU_TILE_ID_WIDTH-1:0]       d_lt_n, d_dt_n;
  logic [NOU_PKT_ID_WIDTH-1:0]        d_pid_n;
  logic [NOU_PKT_HEADER_SZ_WIDTH-1:0] d_hs_n;
  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   d_ds_n;
  logic [NOU_FLIT_SZ_WIDTH-1:0]       d_fn_n;

  rpu_ibd_pkt_tracker u_dut (
    .clk(clk), .rst(rst), .ib_vld(ib_vld), .id_ready(id_ready), .ib_type(ib_type),
    .lreg_vld(lreg_vld), .trans_id(trans_id), .local_tile_id(local_tile_id),
    .dst_tile_id(dst_tile_id), .pkt_id(pkt_id), .pkt_header_size(pkt_header_size),
    .pkt_data_size(pkt_data_size), .pkt_flit_num(pkt_flit_num), .cfg_tile_id(cfg_tile_id),
    .busy(busy_w), .rx_flit_cnt(cnt_w), .pkt_done(done_w),
    .pkt_desc_trans_id(d_tid_w), .pkt_desc_local_tile_id(d_lt_w), .pkt_desc_dst_tile_id(d_dt_w),
    .pkt_desc_pkt_id(d_pid_w), .pkt_desc_header_size(d_hs_w), .pkt_desc_data_size(d_ds_w),
    .pkt_desc_flit_num(d_fn_w), .err_len(len_w), .err_dst(dst_w), .err_orphan(orph_w),
    .err_abort(abort_w)
  );

  rpu_ibd_pkt_tracker #(.CNT_W(2)) u_dut_n (
    .clk(clk), .rst(rst), .ib_vld(ib_vld), .id_ready(id_ready), .ib_type(ib_type),
    .lreg_vld(lreg_vld), .trans_id(trans_id), .local_tile_id(local_tile_id),
    .dst_tile_id(dst_tile_id), .pkt_id(pkt_id), .pkt_header_size(pkt_header_size),
    .pkt_data_size(pkt_data_size), .pkt_flit_num(pkt_flit_num), .cfg_tile_id(cfg_tile_id),
    .busy(busy_n), .rx_flit_cnt(cnt_n), .pkt_done(done_n),
    .pkt_desc_trans_id(d_tid_n), .pkt_desc_local_tile_id(d_lt_n), .pkt_desc_dst_tile_id(d_dt_n),
    .pkt_desc_pkt_id(d_pid_n), .pkt_desc_header_size(d_hs_n), .pkt_desc_data_size(d_ds_n),
    .pkt_desc_flit_num(d_fn_n), .err_len(len_n), .err_dst(dst_n), .err_orphan(orph_n),
    .err_abort(abort_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: packets are tracked with an unbounded count and completions go through a queue;
  // a completion popped on an edge owns the descriptor for that cycle, otherwise the latest head does.
  typedef struct {
    pkt_desc_t d;
    bit        len0;
    bit        len1;
    bit        dst;
  } comp_t;

  bit        m_busy, m_dsterr;
  pkt_desc_t m_cur;
  int        m_cnt[2];
  bit        m_over[2];
  comp_t     m_q[$];
  bit        e_done, e_dst, e_orph, e_abort;
  bit        e_len[2];
  pkt_desc_t e_desc;

  function automatic int sat(input int k, input int v);
    int m;
    m = (k == 0) ? 255 : 3;
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_dsterr = 0; m_cur = '0;
    m_cnt = '{0, 0}; m_over = '{0, 0};
    m_q.delete();
    e_done = 0; e_dst = 0; e_orph = 0; e_abort = 0; e_len = '{0, 0}; e_desc = '0;
  endtask

  task automatic model_edge();
    pkt_desc_t nd;
    comp_t     c;
    bit        flit, tail;
    bit        lens[2];
    int        fin;
    nd = {trans_id, local_tile_id, dst_tile_id, pkt_id, pkt_header_size, pkt_data_size, pkt_flit_num};
    e_orph = 0; e_abort = 0;
    flit = ib_vld && id_ready && !lreg_vld && (ib_type != HEAD_FLIT_TYPE);
    tail = flit && (ib_type == TAIL_FLIT_TYPE);
    if (lreg_vld) begin
      if (m_busy) begin
        e_abort = 1;
        c.d = m_cur; c.len0 = 1; c.len1 = 1; c.dst = m_dsterr;
        m_q.push_back(c);
      end
      m_cur = nd; m_dsterr = (dst_tile_id != cfg_tile_id);
      m_cnt = '{1, 1}; m_over = '{0, 0};
      if (pkt_flit_num <= 1) begin
        c.d = nd; c.len0 = (pkt_flit_num == 0); c.len1 = c.len0; c.dst = m_dsterr;
        m_q.push_back(c);
        m_busy = 0;
      end else begin
        m_busy = 1;
      end
    end else if (flit) begin
      if (!m_busy) begin
        e_orph = 1;
      end else begin
        for (int k = 0; k < 2; k++) begin
          fin = sat(k, m_cnt[k]) + 1;
          m_cnt[k]++;
          if (!tail && sat(k, m_cnt[k]) == int'(m_cur.flit_num)) m_over[k] = 1;
          lens[k] = (fin != int'(m_cur.flit_num)) || m_over[k];
        end
        if (tail) begin
          c.d = m_cur; c.len0 = lens[0]; c.len1 = lens[1]; c.dst = m_dsterr;
          m_q.push_back(c);
          m_busy = 0;
        end
      end
    end
    if (m_q.size() > 0) begin
      c = m_q.pop_front();
      e_done = 1; e_desc = c.d; e_len = '{c.len0, c.len1}; e_dst = c.dst;
    end else begin
      e_done = 0; e_desc = m_cur; e_len = '{0, 0}; e_dst = 0;
    end
  endtask

  task automatic compare_all(input string name);
    logic [7:0] ec_w;
    logic [1:0] ec_n;
    ec_w = 8'(sat(0, m_cnt[0]));
    ec_n = 2'(sat(1, m_cnt[1]));
    chk({name, "_ctrl"},
        64'({busy_w, busy_n, cnt_w, cnt_n, done_w, done_n, len_w, len_n,
             dst_w, dst_n, orph_w, orph_n, abort_w, abort_n}),
        64'({m_busy, m_busy, ec_w, ec_n, e_done, e_done, e_len[0], e_len[1],
             e_dst, e_dst, e_orph, e_orph, e_abort, e_abort}));
    chk({name, "_desc_w"}, 64'({d_tid_w, d_lt_w, d_dt_w, d_pid_w, d_hs_w, d_ds_w, d_fn_w}), 64'(e_desc));
    chk({name, "_desc_n"}, 64'({d_tid_n, d_lt_n, d_dt_n, d_pid_n, d_hs_n, d_ds_n, d_fn_n}), 64'(e_desc));
  endtask

  // ev: 0 idle, 1 head, 2 body, 3 tail, 4 stalled body, 5 unlisted type code
  task automatic drv(input int ev, input logic [7:0] fn, input logic [15:0] pid, input logic [3:0] dst);
    ib_vld   = (ev != 0);
    id_ready = (ev != 4);
    lreg_vld = (ev == 1);
    ib_type  = (ev == 1) ? HEAD_FLIT_TYPE : (ev == 3) ? TAIL_FLIT_TYPE :
               (ev == 5) ? NOU_TYPE_WIDTH'(3) : BODY_FLIT_TYPE;
    pkt_flit_num    = fn;
    pkt_id          = pid;
    dst_tile_id     = dst;
    trans_id        = pid[7:0] ^ 8'h5A;
    local_tile_id   = pid[3:0];
    pkt_header_size = fn[3:0];
    pkt_data_size   = pid[11:0];
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(name);
  endtask

  typedef struct {
    int          ev;
    logic [7:0]  fn;
    logic [15:0] pid;
    logic        done, len, busy, orph;
    logic [7:0]  cnt;
    logic [15:0] epid;
  } vec_t;

  vec_t tbl[25];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 8'd4, 16'h1234, 0, 0, 1, 0, 8'd1, 16'h1234};
    tbl[1]  = '{2, 8'd0, 16'h0000, 0, 0, 1, 0, 8'd2, 16'h1234};
    tbl[2]  = '{2, 8'd0, 16'h0000, 0, 0, 1, 0, 8'd3, 16'h1234};
    tbl[3]  = '{3, 8'd0, 16'h0000, 1, 0, 0, 0, 8'd4, 16'h1234};
    tbl[4]  = '{0, 8'd0, 16'h0000, 0, 0, 0, 0, 8'd4, 16'h1234};
    tbl[5]  = '{1, 8'd4, 16'h0002, 0, 0, 1, 0, 8'd1, 16'h0002};
    tbl[6]  = '{2, 8'd0, 16'h0000, 0, 0, 1, 0, 8'd2, 16'h0002};
    tbl[7]  = '{3, 8'd0, 16'h0000, 1, 1, 0, 0, 8'd3, 16'h0002};
    tbl[8]  = '{1, 8'd3, 16'h0003, 0, 0, 1, 0, 8'd1, 16'h0003};
    tbl[9]  = '{2, 8'd0, 16'h0000, 0, 0, 1, 0, 8'd2, 16'h0003};
    tbl[10] = '{2, 8'd0, 16'h0000, 0, 0, 1, 0, 8'd3, 16'h0003};
    tbl[11] = '{2, 8'd0, 16'h0000, 0, 0, 1, 0, 8'd4, 16'h0003};
    tbl[12] = '{3, 8'd0, 16'h0000, 1, 1, 0, 0, 8'd5, 16'h0003};
    tbl[13] = '{1, 8'd1, 16'h0011, 1, 0, 0, 0, 8'd1, 16'h0011};
    tbl[14] = '{0, 8'd0, 16'h0000, 0, 0, 0, 0, 8'd1, 16'h0011};
    tbl[15] = '{1, 8'd0, 16'h0010, 1, 1, 0, 0, 8'd1, 16'h0010};
    tbl[16] = '{3, 8'd0, 16'h0000, 0, 0, 0, 1, 8'd1, 16'h0010};
    tbl[17] = '{5, 8'd0, 16'h0000, 0, 0, 0, 1, 8'd1, 16'h0010};
    tbl[18] = '{1, 8'd2, 16'h0020, 0, 0, 1, 0, 8'd1, 16'h0020};
    for (int i = 19; i < 24; i++) tbl[i] = '{4, 8'd0, 16'h0000, 0, 0, 1, 0, 8'd1, 16'h0020};
    tbl[24] = '{3, 8'd0, 16'h0000, 1, 0, 0, 0, 8'd2, 16'h0020};

    rst = 1'b1;
    cfg_tile_id = 4'h5;
    drv(0, 8'd0, 16'h0, 4'h5);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drv(tbl[i].ev, tbl[i].fn, tbl[i].pid, 4'h5);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_exp", i),
          64'({done_w, len_w, busy_w, orph_w, cnt_w, d_pid_w}),
          64'({tbl[i].done, tbl[i].len, tbl[i].busy, tbl[i].orph, tbl[i].cnt, tbl[i].epid}));
    end

    // Narrow counter: three bodies on a three-flit packet pin the 2-bit count at 3.
    drv(1, 8'd3, 16'h0033, 4'h5); step("sat_h");
    for (int i = 0; i < 3; i++) begin drv(2, 8'd0, 16'h0, 4'h5); step("sat_b"); end
    chk("sat_cnt_n", 64'(cnt_n), 64'd3);
    drv(3, 8'd0, 16'h0, 4'h5); step("sat_t");
    chk("sat_done_n", 64'({done_n, len_n, cnt_n}), 64'({1'b1, 1'b1, 2'd3}));
    chk("sat_cnt_w", 64'(cnt_w), 64'd5);

    // Head B arrives mid-packet A.
    drv(1, 8'd4, 16'hAAAA, 4'h5); step("ab_a");
    drv(2, 8'd0, 16'h0, 4'h5);    step("ab_b1");
    drv(1, 8'd3, 16'hBBBB, 4'h5); step("ab_hb");
    chk("abort_pulse", 64'({abort_w, done_w, len_w, busy_w}), 64'(4'b1111));
    chk("abort_pid", 64'(d_pid_w), 64'(16'hAAAA));
    drv(2, 8'd0, 16'h0, 4'h5);    step("ab_bb");
    chk("abort_newdesc", 64'({abort_w, done_w, d_pid_w, cnt_w}), 64'({2'b00, 16'hBBBB, 8'd2}));
    drv(3, 8'd0, 16'h0, 4'h5);    step("ab_bt");
    chk("abort_b_done", 64'({done_w, len_w, busy_w, d_pid_w, cnt_w}), 64'({3'b100, 16'hBBBB, 8'd3}));

    // Abort by a single-flit head: two completions on consecutive cycles.
    drv(1, 8'd4, 16'hC1C1, 4'h5); step("as_c");
    drv(1, 8'd1, 16'hD1D1, 4'h5); step("as_d");
    chk("abort_single_1", 64'({done_w, len_w, busy_w, d_pid_w}), 64'({3'b110, 16'hC1C1}));
    drv(0, 8'd0, 16'h0, 4'h5);    step("as_i");
    chk("abort_single_2", 64'({done_w, len_w, busy_w, d_pid_w}), 64'({3'b100, 16'hD1D1}));

    // Destination mismatch.
    drv(1, 8'd1, 16'h0300, 4'h3); step("dst_h");
    chk("dst_err", 64'({done_w, dst_w}), 64'(2'b11));
    drv(0, 8'd0, 16'h0, 4'h5);    step("dst_i");
    chk("dst_clear", 64'({done_w, dst_w}), 64'(2'b00));

    // Reset mid-packet.
    drv(1, 8'd5, 16'h0500, 4'h5); step("rs_h");
    drv(2, 8'd0, 16'h0, 4'h5);    step("rs_b");
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    drv(0, 8'd0, 16'h0, 4'h5);
    @(posedge clk);
    #1 rst = 1'b0;
    drv(1, 8'd2, 16'h0600, 4'h5); step("rs_h2");
    drv(3, 8'd0, 16'h0, 4'h5);    step("rs_t2");
    chk("post_rst", 64'({done_w, len_w, cnt_w, d_pid_w}), 64'({2'b10, 8'd2, 16'h0600}));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r, ev;
      r = int'($urandom_range(0, 99));
      ev = (r < 15) ? 1 : (r < 50) ? 2 : (r < 70) ? 3 : (r < 80) ? 4 : (r < 85) ? 5 : 0;
      drv(ev, 8'($urandom_range(0, 6)), 16'($urandom), 4'($urandom_range(4, 6)));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
